// File: rtl/load_store_unit.sv
// RV32I load/store initiator: turns byte/half/word accesses into word transactions
// on a req/ack memory port, with lane extraction, sign extension and read-modify-write.
module load_store_unit #(
    parameter int unsigned WORD_ADDR_WIDTH = 10,
    parameter int unsigned TIMEOUT         = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       is_store,
    input  logic [2:0]                 funct3,
    input  logic [31:0]                addr,
    input  logic [31:0]                wdata,
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                rdata,
    output logic                       err_access,
    output logic                       err_timeout,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [WORD_ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic [31:0]                mem_rdata,
    input  logic                       mem_ack
);

    localparam int unsigned AW = WORD_ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic            r_store;
    logic [2:0]      r_funct3;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_err_access;
    logic            r_err_timeout;
    logic [31:0]     r_cnt;

    logic            w_illegal;
    logic            w_misaligned;
    logic            w_bad;
    logic            w_tmo;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_ext;
    logic [31:0]     w_merged;
    logic            w_unused_addr;

    // Upper byte-address bits never reach memory; the word index simply wraps.
    assign w_unused_addr = ^addr[31:AW];

    // Access legality is judged on the live inputs, since it is needed in the accept cycle.
    always_comb begin
        w_illegal = 1'b0;
        if (is_store) begin
            w_illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
        end else begin
            w_illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
                          funct3 == 3'b100 || funct3 == 3'b101);
        end
    end

    always_comb begin
        w_misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   w_misaligned = addr[0];
            2'b10:   w_misaligned = (addr[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
    end

    assign w_bad = w_illegal || w_misaligned;

    assign w_tmo = (TIMEOUT != 0) && !mem_ack && (r_cnt == TIMEOUT - 1);

    assign w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = mem_rdata[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_ext = mem_rdata;
        case (r_funct3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'h000000, w_byte};
            3'b101:  w_ext = {16'h0000, w_half};
            default: w_ext = mem_rdata;
        endcase
    end

    // Sub-word store: splice the new byte/half into the word just read.
    always_comb begin
        w_merged = mem_rdata;
        if (r_funct3[1:0] == 2'b00) begin
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_bad) begin
                        w_state_next = S_DONE;
                    end else if (is_store && funct3 == 3'b010) begin
                        w_state_next = S_WRITE;
                    end else begin
                        w_state_next = S_READ;
                    end
                end
            end
            S_READ: begin
                if (mem_ack) begin
                    w_state_next = r_store ? S_WRITE : S_DONE;
                end else if (w_tmo) begin
                    w_state_next = S_DONE;
                end
            end
            S_WRITE: begin
                if (mem_ack || w_tmo) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state != S_IDLE);
        done    = (r_state == S_DONE);
        mem_req = (r_state == S_READ) || (r_state == S_WRITE);
        mem_we  = (r_state == S_WRITE);
    end

    assign rdata       = r_rdata;
    assign err_access  = r_err_access;
    assign err_timeout = r_err_timeout;
    assign mem_addr    = r_addr[AW-1:2];
    assign mem_wdata   = r_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_store       <= 1'b0;
            r_funct3      <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_err_access  <= 1'b0;
            r_err_timeout <= 1'b0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_store       <= is_store;
                        r_funct3      <= funct3;
                        r_addr        <= addr[AW-1:0];
                        r_wdata       <= wdata;
                        r_rdata       <= '0;
                        r_err_access  <= w_bad;
                        r_err_timeout <= 1'b0;
                        r_cnt         <= '0;
                    end
                end
                S_READ: begin
                    if (mem_ack) begin
                        r_cnt <= '0;
                        if (r_store) begin
                            r_wdata <= w_merged;
                        end else begin
                            r_rdata <= w_ext;
                        end
                    end else if (w_tmo) begin
                        r_err_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_WRITE: begin
                    if (!mem_ack) begin
                        if (w_tmo) begin
                            r_err_timeout <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a word memory model with programmable ack
// delay, hand-computed load/store results, latencies and error flags.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err_access;
    logic        err_timeout;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic [31:0] mem [0:1023];
    logic        ack_en;
    int          ack_delay;
    int          wait_cnt;

    int          tests;
    int          fails;
    int          cyc;
    int          nreq;
    int          nwrite;
    int          ndone;
    int          done_cyc;
    logic [31:0] last_waddr;
    logic [31:0] last_wdata;

    load_store_unit #(.WORD_ADDR_WIDTH(10), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .err_access (err_access),
        .err_timeout(err_timeout),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = mem_req && ack_en && (wait_cnt >= ack_delay);

    always @(posedge clk) begin
        if (rst || !mem_req || mem_ack) wait_cnt <= 0;
        else                            wait_cnt <= wait_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        @(posedge clk); #1;
        is_store = st;
        funct3   = f3;
        addr     = a;
        wdata    = wd;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    // Runs from cycle 1 until done, applying writes to the memory model.
    task automatic wait_done();
        logic found;
        found  = 1'b0;
        cyc    = 1;
        nreq   = 0;
        nwrite = 0;
        for (int k = 0; k < 64 && !found; k++) begin
            if (mem_req) nreq++;
            if (mem_req && mem_we && mem_ack) begin
                mem[mem_addr] = mem_wdata;
                nwrite++;
                last_waddr = 32'(mem_addr);
                last_wdata = mem_wdata;
            end
            if (done) begin
                found = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!found) cyc = -1;
    endtask

    initial begin
        tests = 0; fails = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[7]    = 32'h00000020;
        mem[28]   = 32'h80FF1234;
        rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = '0; wdata = '0; ack_en = 1'b1; ack_delay = 0;
        last_waddr = '0; last_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_busy",    32'(busy), 32'd0);
        check("reset_done",    32'(done), 32'd0);
        check("reset_mem_req", 32'(mem_req), 32'd0);
        check("reset_rdata",   rdata, 32'h0);
        check("reset_errs",    32'({err_access, err_timeout}), 32'd0);

        // LW word 7
        issue(1'b0, 3'b010, 32'h1C, 32'h0);
        check("lw_addr", 32'(mem_addr), 32'd7);
        wait_done();
        check("lw_cycle", 32'(cyc), 32'd2);
        check("lw_nreq",  32'(nreq), 32'd1);
        check("lw_rdata", rdata, 32'h00000020);
        check("lw_errs",  32'({err_access, err_timeout}), 32'd0);
        check("lw_busy_in_done", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("lw_idle_after", 32'({busy, done}), 32'd0);
        check("lw_rdata_held", rdata, 32'h00000020);

        // Lane extraction from 0x80FF1234
        issue(1'b0, 3'b000, 32'h73, 32'h0); wait_done();
        check("lb_73", rdata, 32'hFFFFFF80);
        issue(1'b0, 3'b100, 32'h73, 32'h0); wait_done();
        check("lbu_73", rdata, 32'h00000080);
        issue(1'b0, 3'b001, 32'h72, 32'h0); wait_done();
        check("lh_72", rdata, 32'hFFFF80FF);
        issue(1'b0, 3'b101, 32'h70, 32'h0); wait_done();
        check("lhu_70", rdata, 32'h00001234);
        issue(1'b0, 3'b000, 32'h71, 32'h0); wait_done();
        check("lb_71", rdata, 32'h00000012);
        // Index wraps modulo 1024 words
        issue(1'b0, 3'b010, 32'hFFFF_F01C, 32'h0); wait_done();
        check("lw_wrap", rdata, 32'h00000020);

        // Sub-word stores via read-modify-write
        issue(1'b1, 3'b000, 32'd29, 32'h123456AB); wait_done();
        check("sb_cycle",  32'(cyc), 32'd3);
        check("sb_nreq",   32'(nreq), 32'd2);
        check("sb_nwrite", 32'(nwrite), 32'd1);
        check("sb_waddr",  last_waddr, 32'd7);
        check("sb_wdata",  last_wdata, 32'h0000AB20);
        check("sb_rdata",  rdata, 32'h0);
        issue(1'b1, 3'b001, 32'd30, 32'h0000BEEF); wait_done();
        check("sh_cycle", 32'(cyc), 32'd3);
        check("sh_wdata", last_wdata, 32'hBEEFAB20);
        check("sh_mem7",  mem[7], 32'hBEEFAB20);

        // SW goes straight to WRITE
        issue(1'b1, 3'b010, 32'h40, 32'hDEADBEEF); wait_done();
        check("sw_cycle", 32'(cyc), 32'd2);
        check("sw_nreq",  32'(nreq), 32'd1);
        check("sw_mem16", mem[16], 32'hDEADBEEF);

        // Access errors: no memory traffic, done in cycle 1
        issue(1'b0, 3'b010, 32'h1E, 32'h0); wait_done();
        check("lw_mis_cycle", 32'(cyc), 32'd1);
        check("lw_mis_err",   32'({err_access, err_timeout}), 32'd2);
        check("lw_mis_nreq",  32'(nreq), 32'd0);
        issue(1'b0, 3'b011, 32'h0, 32'h0); wait_done();
        check("f3_011_cycle", 32'(cyc), 32'd1);
        check("f3_011_err",   32'(err_access), 32'd1);
        check("f3_011_nreq",  32'(nreq), 32'd0);
        issue(1'b1, 3'b100, 32'h0, 32'h0); wait_done();
        check("st_f3_100_err", 32'(err_access), 32'd1);
        issue(1'b0, 3'b001, 32'h71, 32'h0); wait_done();
        check("lh_odd_err",  32'(err_access), 32'd1);
        check("lh_odd_nreq", 32'(nreq), 32'd0);
        issue(1'b1, 3'b001, 32'h72, 32'h0); wait_done();
        check("sh_aligned_ok", 32'({err_access, err_timeout}), 32'd0);

        // Timeouts
        ack_en = 1'b0;
        issue(1'b0, 3'b010, 32'h1C, 32'h0); wait_done();
        check("tmo_lw_cycle", 32'(cyc), 32'd17);
        check("tmo_lw_nreq",  32'(nreq), 32'd16);
        check("tmo_lw_err",   32'({err_access, err_timeout}), 32'd1);
        check("tmo_lw_req_low", 32'(mem_req), 32'd0);
        issue(1'b1, 3'b000, 32'h50, 32'h000000AA); wait_done();
        check("tmo_sb_cycle",  32'(cyc), 32'd17);
        check("tmo_sb_nwrite", 32'(nwrite), 32'd0);
        check("tmo_sb_err",    32'(err_timeout), 32'd1);
        check("tmo_sb_mem20",  mem[20], 32'h0);

        // Wait states
        ack_en = 1'b1; ack_delay = 3;
        issue(1'b0, 3'b010, 32'h1C, 32'h0); wait_done();
        check("wait3_cycle", 32'(cyc), 32'd5);
        check("wait3_rdata", rdata, 32'hBEEFAB20);
        check("wait3_errs",  32'({err_access, err_timeout}), 32'd0);

        // start held through busy and DONE cycles is ignored
        issue(1'b0, 3'b010, 32'h1C, 32'h0);
        is_store = 1'b1; funct3 = 3'b010; addr = 32'h48; wdata = 32'h55;
        start = 1'b1;
        ndone = 0; done_cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            if (done) begin
                ndone++;
                done_cyc = k;
            end
            start = (ndone == 0) || done;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("busy_start_ndone", 32'(ndone), 32'd1);
        check("busy_start_cycle", 32'(done_cyc), 32'd5);
        check("busy_start_rdata", rdata, 32'hBEEFAB20);
        check("busy_start_mem18", mem[18], 32'h0);
        check("busy_start_idle",  32'(busy), 32'd0);

        // Reset during a stalled write
        ack_en = 1'b0; ack_delay = 0;
        issue(1'b1, 3'b010, 32'h44, 32'hCAFEF00D);
        repeat (2) begin @(posedge clk); #1; end
        check("rst_pre_we", 32'({mem_req, mem_we}), 32'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_busy",    32'(busy), 32'd0);
        check("rst_mid_mem_req", 32'(mem_req), 32'd0);
        check("rst_mid_done",    32'(done), 32'd0);
        check("rst_mid_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;
        ack_en = 1'b1;
        check("rst_mid_mem17", mem[17], 32'h0);
        issue(1'b0, 3'b010, 32'h40, 32'h0); wait_done();
        check("post_rst_cycle", 32'(cyc), 32'd2);
        check("post_rst_rdata", rdata, 32'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
